// File: rtl/ramb4_s1_arb.sv
// Round-robin A/B arbiter in front of a 4096x1 single-port block RAM.
// Optional full-RAM clear engine compiled in with RAMB4_S1_ARB_CLEAR_EN.
module ramb4_s1_arb (
    input  logic        CLK,
    input  logic        RST,
    input  logic        A_REQ,
    input  logic        A_WE,
    input  logic [11:0] A_ADDR,
    input  logic        A_DI,
    output logic        A_ACK,
    output logic        A_VLD,
    output logic        A_DO,
    input  logic        B_REQ,
    input  logic        B_WE,
    input  logic [11:0] B_ADDR,
    input  logic        B_DI,
    output logic        B_ACK,
    output logic        B_VLD,
    output logic        B_DO,
    input  logic        CLR_START,
    output logic        CLR_BUSY,
    output logic        RAM_EN,
    output logic        RAM_WE,
    output logic        RAM_RST,
    output logic [11:0] RAM_ADDR,
    output logic        RAM_DI,
    input  logic        RAM_DO
);
    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    logic        last_q, last_d;
    logic        a_vld_q, b_vld_q;
    logic        busy;
    logic        arb_ok;
    logic        grant_a, grant_b;
    logic [11:0] clr_addr;

`ifdef RAMB4_S1_ARB_CLEAR_EN
    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [11:0] clr_cnt_q, clr_cnt_d;

    // Counter wraps 4095 -> 0 on exit, so it is already 0 for the next clear.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_ARB) begin
            if (CLR_START) begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        end else begin
            clr_cnt_d = clr_cnt_q + 12'd1;
            if (clr_cnt_q == 12'hFFF)
                state_d = ST_ARB;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_ARB;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign busy     = (state_q == ST_CLEAR);
    assign clr_addr = clr_cnt_q;
`else
    logic unused_clr_start;
    assign unused_clr_start = CLR_START;
    assign busy             = 1'b0;
    assign clr_addr         = '0;
`endif

    assign CLR_BUSY = busy;

    // Conflicts go to whoever was not granted last.
    assign arb_ok  = !RST && !busy;
    assign grant_a = arb_ok && A_REQ && (!B_REQ || (last_q == LAST_B));
    assign grant_b = arb_ok && B_REQ && (!A_REQ || (last_q == LAST_A));

    assign A_ACK = grant_a;
    assign B_ACK = grant_b;

    always_comb begin
        last_d = last_q;
        if (grant_a)
            last_d = LAST_A;
        else if (grant_b)
            last_d = LAST_B;
    end

    always_comb begin
        RAM_EN   = 1'b0;
        RAM_WE   = 1'b0;
        RAM_ADDR = A_ADDR;
        RAM_DI   = A_DI;
        if (busy && !RST) begin
            RAM_EN   = 1'b1;
            RAM_WE   = 1'b1;
            RAM_ADDR = clr_addr;
            RAM_DI   = 1'b0;
        end else if (grant_a) begin
            RAM_EN   = 1'b1;
            RAM_WE   = A_WE;
        end else if (grant_b) begin
            RAM_EN   = 1'b1;
            RAM_WE   = B_WE;
            RAM_ADDR = B_ADDR;
            RAM_DI   = B_DI;
        end
    end

    assign RAM_RST = 1'b0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q  <= LAST_B;
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
        end else begin
            last_q  <= last_d;
            a_vld_q <= grant_a;
            b_vld_q <= grant_b;
        end
    end

    // RAM output is write-first, so writes return the written bit too.
    assign A_VLD = a_vld_q;
    assign B_VLD = b_vld_q;
    assign A_DO  = RAM_DO & a_vld_q;
    assign B_DO  = RAM_DO & b_vld_q;

endmodule
